// File: rtl/reservation_station.sv
// Reservation station: holds renamed ALU instructions until both operands arrive, issues one per cycle.
// Optional macro RS_BYPASS_EN lets a fully ready dispatch issue at once when nothing stored is ready.
module reservation_station #(
    parameter int RS_WIDTH     = 3,
    parameter int RoB_WIDTH    = 4,
    parameter int EX_RoB_WIDTH = 5,
    parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = EX_RoB_WIDTH'(1 << RoB_WIDTH)
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    RoBRS_pre_judge,
    input  logic                    DPRS_en,
    input  logic [31:0]             DPRS_pc,
    input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
    input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
    input  logic [31:0]             DPRS_Vj,
    input  logic [31:0]             DPRS_Vk,
    input  logic [31:0]             DPRS_imm,
    input  logic [6:0]              DPRS_opcode,
    input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
    output logic                    RSDP_full,
    input  logic                    CDBRS_RS_en,
    input  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index,
    input  logic [31:0]             CDBRS_RS_value,
    input  logic                    CDBRS_LSB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
    input  logic [31:0]             CDBRS_LSB_value,
    output logic                    RSALU_en,
    output logic [6:0]              RSALU_opcode,
    output logic [31:0]             RSALU_Vj,
    output logic [31:0]             RSALU_Vk,
    output logic [31:0]             RSALU_imm,
    output logic [31:0]             RSALU_pc,
    output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);
    localparam int RS_SIZE = 1 << RS_WIDTH;

    logic [RS_SIZE-1:0]      busy;
    logic [EX_RoB_WIDTH-1:0] qj  [RS_SIZE];
    logic [EX_RoB_WIDTH-1:0] qk  [RS_SIZE];
    logic [31:0]             vj  [RS_SIZE];
    logic [31:0]             vk  [RS_SIZE];
    logic [31:0]             imm [RS_SIZE];
    logic [31:0]             pc  [RS_SIZE];
    logic [6:0]              op  [RS_SIZE];
    logic [RoB_WIDTH-1:0]    rob [RS_SIZE];

    logic [RS_SIZE-1:0]      ready;
    logic                    issue_found;
    logic [RS_WIDTH-1:0]     issue_idx;
    logic                    free_found;
    logic [RS_WIDTH-1:0]     free_idx;
    logic [RS_WIDTH:0]       busy_count;
    logic [EX_RoB_WIDTH-1:0] in_qj;
    logic [EX_RoB_WIDTH-1:0] in_qk;
    logic [31:0]             in_vj;
    logic [31:0]             in_vk;
    logic                    bypass;
    logic                    alloc;

    function automatic logic tag_hit(input logic en, input logic [RoB_WIDTH-1:0] idx,
                                     input logic [EX_RoB_WIDTH-1:0] q);
        return en && (q == EX_RoB_WIDTH'(idx));
    endfunction

    // Dispatch operands snoop both buses; the RS bus takes priority on a double match.
    always_comb begin
        in_qj = DPRS_Qj;
        in_vj = DPRS_Vj;
        in_qk = DPRS_Qk;
        in_vk = DPRS_Vk;
        if (tag_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, DPRS_Qj)) begin
            in_qj = NON_DEP;
            in_vj = CDBRS_RS_value;
        end else if (tag_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, DPRS_Qj)) begin
            in_qj = NON_DEP;
            in_vj = CDBRS_LSB_value;
        end
        if (tag_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, DPRS_Qk)) begin
            in_qk = NON_DEP;
            in_vk = CDBRS_RS_value;
        end else if (tag_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, DPRS_Qk)) begin
            in_qk = NON_DEP;
            in_vk = CDBRS_LSB_value;
        end
    end

    always_comb begin
        ready       = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        busy_count  = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ready[i]   = busy[i] && (qj[i] == NON_DEP) && (qk[i] == NON_DEP);
            busy_count = busy_count + (RS_WIDTH+1)'(busy[i]);
            if (ready[i] && !issue_found) begin
                issue_found = 1'b1;
                issue_idx   = RS_WIDTH'(i);
            end
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end
        end
    end

`ifdef RS_BYPASS_EN
    assign bypass = DPRS_en && (in_qj == NON_DEP) && (in_qk == NON_DEP) && !issue_found;
`else
    assign bypass = 1'b0;
`endif

    assign alloc     = DPRS_en && free_found && !bypass;
    assign RSDP_full = busy_count >= (RS_WIDTH+1)'(RS_SIZE - 1);

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst || !RoBRS_pre_judge) begin
            busy            <= '0;
            RSALU_en        <= 1'b0;
            RSALU_opcode    <= '0;
            RSALU_Vj        <= '0;
            RSALU_Vk        <= '0;
            RSALU_imm       <= '0;
            RSALU_pc        <= '0;
            RSALU_RoB_index <= '0;
        end else if (Sys_rdy) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (tag_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, qj[i])) begin
                        qj[i] <= NON_DEP;
                        vj[i] <= CDBRS_RS_value;
                    end else if (tag_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, qj[i])) begin
                        qj[i] <= NON_DEP;
                        vj[i] <= CDBRS_LSB_value;
                    end
                    if (tag_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, qk[i])) begin
                        qk[i] <= NON_DEP;
                        vk[i] <= CDBRS_RS_value;
                    end else if (tag_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, qk[i])) begin
                        qk[i] <= NON_DEP;
                        vk[i] <= CDBRS_LSB_value;
                    end
                end
            end

            if (issue_found) begin
                RSALU_en          <= 1'b1;
                RSALU_opcode      <= op[issue_idx];
                RSALU_Vj          <= vj[issue_idx];
                RSALU_Vk          <= vk[issue_idx];
                RSALU_imm         <= imm[issue_idx];
                RSALU_pc          <= pc[issue_idx];
                RSALU_RoB_index   <= rob[issue_idx];
                busy[issue_idx]   <= 1'b0;
            end else if (bypass) begin
                RSALU_en        <= 1'b1;
                RSALU_opcode    <= DPRS_opcode;
                RSALU_Vj        <= in_vj;
                RSALU_Vk        <= in_vk;
                RSALU_imm       <= DPRS_imm;
                RSALU_pc        <= DPRS_pc;
                RSALU_RoB_index <= DPRS_RoB_index;
            end else begin
                RSALU_en <= 1'b0;
            end

            // The slot being issued is still busy here, so allocation never collides with it.
            if (alloc) begin
                busy[free_idx] <= 1'b1;
                qj[free_idx]   <= in_qj;
                qk[free_idx]   <= in_qk;
                vj[free_idx]   <= in_vj;
                vk[free_idx]   <= in_vk;
                imm[free_idx]  <= DPRS_imm;
                pc[free_idx]   <= DPRS_pc;
                op[free_idx]   <= DPRS_opcode;
                rob[free_idx]  <= DPRS_RoB_index;
            end
        end else begin
            RSALU_en <= 1'b0;
        end
    end

    // Dispatching into a completely full station means the Dispatcher ignored RSDP_full.
    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst && RoBRS_pre_judge && Sys_rdy && DPRS_en)
            assert (!(&busy));
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station: one record per clock cycle with
// the inputs for that cycle and the outputs expected just after its rising edge.
module tb_reservation_station;
    logic        Sys_clk;
    logic        Sys_rst;
    logic        Sys_rdy;
    logic        RoBRS_pre_judge;
    logic        DPRS_en;
    logic [31:0] DPRS_pc;
    logic [4:0]  DPRS_Qj;
    logic [4:0]  DPRS_Qk;
    logic [31:0] DPRS_Vj;
    logic [31:0] DPRS_Vk;
    logic [31:0] DPRS_imm;
    logic [6:0]  DPRS_opcode;
    logic [3:0]  DPRS_RoB_index;
    logic        RSDP_full;
    logic        CDBRS_RS_en;
    logic [3:0]  CDBRS_RS_RoB_index;
    logic [31:0] CDBRS_RS_value;
    logic        CDBRS_LSB_en;
    logic [3:0]  CDBRS_LSB_RoB_index;
    logic [31:0] CDBRS_LSB_value;
    logic        RSALU_en;
    logic [6:0]  RSALU_opcode;
    logic [31:0] RSALU_Vj;
    logic [31:0] RSALU_Vk;
    logic [31:0] RSALU_imm;
    logic [31:0] RSALU_pc;
    logic [3:0]  RSALU_RoB_index;

    reservation_station dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .RoBRS_pre_judge(RoBRS_pre_judge), .DPRS_en(DPRS_en), .DPRS_pc(DPRS_pc),
        .DPRS_Qj(DPRS_Qj), .DPRS_Qk(DPRS_Qk), .DPRS_Vj(DPRS_Vj), .DPRS_Vk(DPRS_Vk),
        .DPRS_imm(DPRS_imm), .DPRS_opcode(DPRS_opcode), .DPRS_RoB_index(DPRS_RoB_index),
        .RSDP_full(RSDP_full),
        .CDBRS_RS_en(CDBRS_RS_en), .CDBRS_RS_RoB_index(CDBRS_RS_RoB_index),
        .CDBRS_RS_value(CDBRS_RS_value),
        .CDBRS_LSB_en(CDBRS_LSB_en), .CDBRS_LSB_RoB_index(CDBRS_LSB_RoB_index),
        .CDBRS_LSB_value(CDBRS_LSB_value),
        .RSALU_en(RSALU_en), .RSALU_opcode(RSALU_opcode), .RSALU_Vj(RSALU_Vj),
        .RSALU_Vk(RSALU_Vk), .RSALU_imm(RSALU_imm), .RSALU_pc(RSALU_pc),
        .RSALU_RoB_index(RSALU_RoB_index)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        logic        rst, rdy, pj, en;
        logic [4:0]  qj, qk;
        logic [31:0] vj, vk;
        logic [3:0]  rob;
        logic        rs_en;
        logic [3:0]  rs_i;
        logic [31:0] rs_v;
        logic        l_en;
        logic [3:0]  l_i;
        logic [31:0] l_v;
        logic        e_en;
        logic [31:0] e_vj, e_vk;
        logic [3:0]  e_rob;
        logic        e_full;
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    // Opcode, pc and imm are tied to the RoB slot so a wrongly chosen entry shows up everywhere.
    function automatic logic [6:0]  op_of(input logic [3:0] r);  return 7'(26 + int'(r)); endfunction
    function automatic logic [31:0] pc_of(input logic [3:0] r);  return 32'h1000 + 32'(r) * 4; endfunction
    function automatic logic [31:0] imm_of(input logic [3:0] r); return 32'h100 + 32'(r); endfunction

    function automatic vec_t mk(input logic en, input logic [4:0] qj, input logic [4:0] qk,
                                input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] rob,
                                input logic rs_en, input logic [3:0] rs_i, input logic [31:0] rs_v,
                                input logic l_en, input logic [3:0] l_i, input logic [31:0] l_v,
                                input logic e_en, input logic [31:0] e_vj, input logic [31:0] e_vk,
                                input logic [3:0] e_rob, input logic e_full);
        vec_t v;
        v.rst = 1'b0; v.rdy = 1'b1; v.pj = 1'b1;
        v.en = en; v.qj = qj; v.qk = qk; v.vj = vj; v.vk = vk; v.rob = rob;
        v.rs_en = rs_en; v.rs_i = rs_i; v.rs_v = rs_v;
        v.l_en = l_en; v.l_i = l_i; v.l_v = l_v;
        v.e_en = e_en; v.e_vj = e_vj; v.e_vk = e_vk; v.e_rob = e_rob; v.e_full = e_full;
        return v;
    endfunction

    function automatic vec_t idle(input logic e_en, input logic [31:0] e_vj, input logic [31:0] e_vk,
                                  input logic [3:0] e_rob, input logic e_full);
        return mk(0, 16, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_en, e_vj, e_vk, e_rob, e_full);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            nmis++;
            $display("FAIL vec %0d %s: got 0x%0h want 0x%0h", nvec, nm, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        Sys_rst = v.rst; Sys_rdy = v.rdy; RoBRS_pre_judge = v.pj;
        DPRS_en = v.en; DPRS_Qj = v.qj; DPRS_Qk = v.qk; DPRS_Vj = v.vj; DPRS_Vk = v.vk;
        DPRS_RoB_index = v.rob; DPRS_opcode = op_of(v.rob);
        DPRS_pc = pc_of(v.rob); DPRS_imm = imm_of(v.rob);
        CDBRS_RS_en = v.rs_en; CDBRS_RS_RoB_index = v.rs_i; CDBRS_RS_value = v.rs_v;
        CDBRS_LSB_en = v.l_en; CDBRS_LSB_RoB_index = v.l_i; CDBRS_LSB_value = v.l_v;
        @(posedge Sys_clk);
        #1;
        nvec++;
        chk("RSALU_en", 32'(RSALU_en), 32'(v.e_en));
        chk("RSDP_full", 32'(RSDP_full), 32'(v.e_full));
        if (v.rst || !v.pj) begin
            chk("clr_opcode", 32'(RSALU_opcode), 0);
            chk("clr_Vj", RSALU_Vj, 0);
            chk("clr_Vk", RSALU_Vk, 0);
            chk("clr_imm", RSALU_imm, 0);
            chk("clr_pc", RSALU_pc, 0);
            chk("clr_RoB_index", 32'(RSALU_RoB_index), 0);
        end else if (v.e_en) begin
            chk("RSALU_Vj", RSALU_Vj, v.e_vj);
            chk("RSALU_Vk", RSALU_Vk, v.e_vk);
            chk("RSALU_RoB_index", 32'(RSALU_RoB_index), 32'(v.e_rob));
            chk("RSALU_opcode", 32'(RSALU_opcode), 32'(op_of(v.e_rob)));
            chk("RSALU_pc", RSALU_pc, pc_of(v.e_rob));
            chk("RSALU_imm", RSALU_imm, imm_of(v.e_rob));
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        // reset
        v = idle(0, 0, 0, 0, 0); v.rst = 1'b1; tbl.push_back(v);
        // ready add, issues one cycle after allocation
        tbl.push_back(mk(1, 16, 16, 3, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 3, 4, 2, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // Qj waits on tag 5, woken by the LSB bus three cycles later
        tbl.push_back(mk(1, 5, 16, 0, 32'h77, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16, 16, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 32'h55, 32'h77, 3, 0));
        // tag resolved by the RS bus in the dispatch cycle
        tbl.push_back(mk(1, 7, 16, 0, 1, 4, 1, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 9, 1, 4, 0));
        // Qj from RS bus, Qk from LSB bus at dispatch
        tbl.push_back(mk(1, 8, 9, 0, 0, 5, 1, 8, 32'hA, 1, 9, 32'hB, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 32'hA, 32'hB, 5, 0));
        // both buses match the same tag: RS bus value wins
        tbl.push_back(mk(1, 6, 6, 0, 0, 6, 1, 6, 32'h66, 1, 6, 32'h99, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 32'h66, 32'h66, 6, 0));
        // seven entries wait on tag 3; full after the seventh, drains in index order
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 3, 16, 0, 32'(i), 4'(8 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i == 6));
        tbl.push_back(mk(0, 16, 16, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(idle(1, 32'h33, 32'(i), 4'(8 + i), 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // Qj and Qk woken in the same cycle from different buses; an unrelated tag first
        tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16, 16, 0, 0, 0, 1, 4, 32'hEE, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16, 16, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 32'h11, 32'h22, 1, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));

        foreach (tbl[k]) apply(tbl[k]);

        // Flush with four waiting entries and a same-cycle dispatch
        for (int i = 0; i < 4; i++)
            apply(mk(1, 3, 16, 0, 0, 4'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = mk(1, 16, 16, 32'h70, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.pj = 1'b0; apply(v);
        apply(mk(0, 16, 16, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(idle(0, 0, 0, 0, 0));
        apply(idle(0, 0, 0, 0, 0));
        // the count restarted at zero: full only after seven fresh dispatches
        for (int i = 0; i < 7; i++)
            apply(mk(1, 2, 16, 0, 0, 4'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i == 6));
        v = idle(0, 0, 0, 0, 0); v.pj = 1'b0; apply(v);
        apply(idle(0, 0, 0, 0, 0));

        // Stall: a ready entry waits out three Sys_rdy=0 cycles; CDB and dispatch then are lost
        apply(mk(1, 4, 16, 0, 32'hA, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 16, 16, 32'h90, 32'h91, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = mk(1, 16, 16, 32'hC0, 32'hC1, 12, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0); v.rdy = 1'b0; apply(v);
        v = idle(0, 0, 0, 0, 0); v.rdy = 1'b0; apply(v);
        v = idle(0, 0, 0, 0, 0); v.rdy = 1'b0; apply(v);
        apply(idle(1, 32'h90, 32'h91, 9, 0));
        apply(idle(0, 0, 0, 0, 0));
        apply(mk(0, 16, 16, 0, 0, 0, 1, 4, 32'h45, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(idle(1, 32'h45, 32'hA, 10, 0));
        apply(idle(0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
